// File: rtl/serial_receiver.sv
// 8N1 serial receiver: 2-flop synchroniser, mid-bit sampling, valid/ready output.
// Define SERIAL_RX_MAJORITY_VOTE_EN for 2-of-3 majority sampling.
module serial_receiver #(
  parameter int CYCLES_PER_BIT = 5000,
  parameter int HALF_BIT       = CYCLES_PER_BIT / 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       serial_rx,
  output logic [7:0] rx_data,
  output logic       rx_data_available,
  input  logic       rx_ready,
  output logic       rx_framing_error,
  output logic       rx_overrun
);

  localparam int TW = $clog2(CYCLES_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(CYCLES_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [2:0]    idx, idx_next;
  logic [7:0]    shift, shift_next;
  logic          sync1, rx_sync;
  logic          sample;
  logic          load, ferr, ovr;

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1   <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      sync1   <= serial_rx;
      rx_sync <= sync1;
    end
  end

`ifdef SERIAL_RX_MAJORITY_VOTE_EN
  // hist[0] is rx_sync one cycle ago, hist[1] two cycles ago
  logic [1:0] hist;

  always_ff @(posedge clock) begin
    if (!reset) hist <= 2'b11;
    else        hist <= {hist[0], rx_sync};
  end

  assign sample = (rx_sync & hist[0]) |
                  (rx_sync & hist[1]) |
                  (hist[0] & hist[1]);
`else
  assign sample = rx_sync;
`endif

  always_comb begin
    state_next = state;
    timer_next = (timer == BIT_LAST) ? '0 : timer + 1'b1;
    idx_next   = idx;
    shift_next = shift;
    load       = 1'b0;
    ferr       = 1'b0;
    ovr        = 1'b0;
    unique case (state)
      IDLE: begin
        timer_next = '0;
        if (!rx_sync) state_next = START;
      end
      START: begin
        if (timer == HALF_LAST) begin
          idx_next   = '0;
          state_next = sample ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == BIT_LAST) begin
          shift_next[idx] = sample;
          idx_next        = idx + 3'd1;
          if (idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (timer == BIT_LAST) begin
          if (sample) begin
            if (!rx_data_available || rx_ready) load = 1'b1;
            else                                ovr  = 1'b1;
            state_next = IDLE;
          end else begin
            ferr       = 1'b1;
            state_next = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        timer_next = '0;
        if (rx_sync) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (state_next != state) timer_next = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state             <= IDLE;
      timer             <= '0;
      idx               <= '0;
      shift             <= '0;
      rx_data           <= 8'h00;
      rx_data_available <= 1'b0;
      rx_framing_error  <= 1'b0;
      rx_overrun        <= 1'b0;
    end else begin
      state            <= state_next;
      timer            <= timer_next;
      idx              <= idx_next;
      shift            <= shift_next;
      rx_framing_error <= ferr;
      rx_overrun       <= ovr;
      if (load) begin
        rx_data           <= shift;
        rx_data_available <= 1'b1;
      end else if (rx_ready) begin
        rx_data_available <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver at 16 cycles per bit.
// Frames are driven by a bench-side 8N1 transmitter model.
module tb_serial_receiver;

  localparam int CPB = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       serial_rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_data_available;
  logic       rx_ready = 1'b1;
  logic       rx_framing_error;
  logic       rx_overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  int ferr_cnt, ovr_cnt, avail_cyc;

  serial_receiver #(.CYCLES_PER_BIT(CPB)) dut (
    .clock(clock),
    .reset(reset),
    .serial_rx(serial_rx),
    .rx_data(rx_data),
    .rx_data_available(rx_data_available),
    .rx_ready(rx_ready),
    .rx_framing_error(rx_framing_error),
    .rx_overrun(rx_overrun)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (rx_data_available && rx_ready) got.push_back(rx_data);
    if (rx_data_available) avail_cyc++;
    if (rx_framing_error) ferr_cnt++;
    if (rx_overrun) ovr_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_log();
    got.delete();
    ferr_cnt  = 0;
    ovr_cnt   = 0;
    avail_cyc = 0;
  endtask

  // glitch inverts the line for the one cycle the receiver samples at mid-bit
  task automatic send(input logic [7:0] b, input logic stop, input logic glitch);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial_rx = f[i];
      tick(8);
      if (glitch) serial_rx = ~f[i];
      tick(1);
      serial_rx = f[i];
      tick(7);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    @(negedge clock);
    checks++;
    if (rx_data !== 8'h00 || rx_data_available !== 1'b0 ||
        rx_framing_error !== 1'b0 || rx_overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got data=%h av=%b fe=%b ov=%b want 00 0 0 0",
               rx_data, rx_data_available, rx_framing_error, rx_overrun);
    end
    reset = 1'b1;
    tick(5);
  endtask

  task automatic test_single();
    clear_log();
    send(8'hA5, 1'b1, 1'b0);
    tick(20);
    checks++;
    if (got.size() != 1 || got[0] !== 8'hA5) begin
      errors++;
      $display("FAIL single_a5 got n=%0d d=%h want n=1 d=a5", got.size(), got[0]);
    end
    checks++;
    if (avail_cyc != 1) begin
      errors++;
      $display("FAIL single_avail_width got %0d want 1", avail_cyc);
    end
    checks++;
    if (ferr_cnt != 0 || ovr_cnt != 0) begin
      errors++;
      $display("FAIL single_no_err got fe=%0d ov=%0d want 0 0", ferr_cnt, ovr_cnt);
    end
  endtask

  task automatic test_glitch();
    clear_log();
    serial_rx = 1'b0;
    tick(4);
    serial_rx = 1'b1;
    tick(40);
    checks++;
    if (got.size() != 0 || avail_cyc != 0) begin
      errors++;
      $display("FAIL glitch_reject got n=%0d av=%0d want 0 0", got.size(), avail_cyc);
    end
    send(8'h3C, 1'b1, 1'b0);
    tick(20);
    checks++;
    if (got.size() != 1 || got[0] !== 8'h3C) begin
      errors++;
      $display("FAIL glitch_then_3c got n=%0d d=%h want n=1 d=3c", got.size(), got[0]);
    end
  endtask

  task automatic test_framing();
    clear_log();
    send(8'h81, 1'b0, 1'b0);
    serial_rx = 1'b0;
    tick(3 * CPB);
    serial_rx = 1'b1;
    tick(2 * CPB);
    checks++;
    if (ferr_cnt != 1) begin
      errors++;
      $display("FAIL framing_pulse got %0d want 1", ferr_cnt);
    end
    checks++;
    if (got.size() != 0) begin
      errors++;
      $display("FAIL framing_discard got n=%0d want 0", got.size());
    end
    send(8'h42, 1'b1, 1'b0);
    tick(20);
    checks++;
    if (got.size() != 1 || got[0] !== 8'h42 || ferr_cnt != 1) begin
      errors++;
      $display("FAIL framing_then_42 got n=%0d d=%h fe=%0d want 1 42 1",
               got.size(), got[0], ferr_cnt);
    end
  endtask

  task automatic test_overrun();
    clear_log();
    rx_ready = 1'b0;
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    tick(20);
    checks++;
    if (rx_data !== 8'h11 || rx_data_available !== 1'b1) begin
      errors++;
      $display("FAIL overrun_hold got d=%h av=%b want 11 1", rx_data, rx_data_available);
    end
    checks++;
    if (ovr_cnt != 1) begin
      errors++;
      $display("FAIL overrun_pulse got %0d want 1", ovr_cnt);
    end
    rx_ready = 1'b1;
    tick(2);
    checks++;
    if (rx_data_available !== 1'b0 || got.size() != 1 || got[0] !== 8'h11) begin
      errors++;
      $display("FAIL overrun_drain got av=%b n=%0d d=%h want 0 1 11",
               rx_data_available, got.size(), got[0]);
    end
  endtask

  task automatic test_reset_midframe();
    clear_log();
    serial_rx = 1'b0;
    tick(CPB);
    serial_rx = 1'b1;
    tick(4 * CPB);
    reset = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(6 * CPB);
    checks++;
    if (got.size() != 0 || avail_cyc != 0 || ferr_cnt != 0) begin
      errors++;
      $display("FAIL reset_abort got n=%0d av=%0d fe=%0d want 0 0 0",
               got.size(), avail_cyc, ferr_cnt);
    end
    send(8'h5A, 1'b1, 1'b0);
    tick(20);
    checks++;
    if (got.size() != 1 || got[0] !== 8'h5A) begin
      errors++;
      $display("FAIL reset_then_5a got n=%0d d=%h want 1 5a", got.size(), got[0]);
    end
  endtask

  task automatic test_back_to_back(input logic glitch);
    clear_log();
    send(8'h00, 1'b1, glitch);
    send(8'hFF, 1'b1, glitch);
    send(8'h55, 1'b1, glitch);
    tick(20);
    checks++;
    if (got.size() != 3) begin
      errors++;
      $display("FAIL b2b_count got %0d want 3", got.size());
    end else begin
      checks++;
      if (got[0] !== 8'h00 || got[1] !== 8'hFF || got[2] !== 8'h55) begin
        errors++;
        $display("FAIL b2b_order got %h %h %h want 00 ff 55", got[0], got[1], got[2]);
      end
    end
    checks++;
    if (ferr_cnt != 0 || ovr_cnt != 0) begin
      errors++;
      $display("FAIL b2b_no_err got fe=%0d ov=%0d want 0 0", ferr_cnt, ovr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
    test_back_to_back(1'b0);
`ifdef SERIAL_RX_MAJORITY_VOTE_EN
    test_back_to_back(1'b1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- 8N1 asynchronous serial receiver; the receive-side counterpart of the team's serial transmitter on the same link (the same 9600 baud from a 48 MHz clock).
- Synchronises the raw serial_rx pin, detects and validates the start bit, and samples 8 data bits LSB-first at mid-bit.
- Checks the stop bit and presents each received byte on a valid/ready holding register to downstream logic such as a command parser or loopback.

Parameters:
- CYCLES_PER_BIT, 5000, clock cycles per bit (48000000 / 9600); must be at least 8. Benches may override it to 16.
- HALF_BIT, CYCLES_PER_BIT/2, cycle offset of the start-bit validation sample.

Ports:
- clock  input  1  system clock, 48 MHz.
- reset  input  1  synchronous, active-low reset: state is reset on a clock edge while reset==0.
- serial_rx  input  1  asynchronous serial line; idle high.
- rx_data  output  8  received byte; stable while rx_data_available==1.
- rx_data_available  output  1  holding register contains an unconsumed byte.
- rx_ready  input  1  consumer accepts the byte; a transfer occurs on any edge with rx_data_available && rx_ready.
- rx_framing_error  output  1  one-cycle pulse: stop bit sampled low.
- rx_overrun  output  1  one-cycle pulse: byte completed while the holding register was still full.

Behaviour:
- Reset (reset==0 at an edge) forces:
  - state IDLE, bit timer 0;
  - rx_data=8'h00, rx_data_available=0, rx_framing_error=0, rx_overrun=0;
  - both synchroniser flops to 1.
- Reset has priority over everything and aborts a byte in flight; no partial byte is ever presented.
- Input path: a 2-flop synchroniser produces rx_sync. All decisions use rx_sync, which lags serial_rx by 2 cycles.
- Bit timer: counts 0..CYCLES_PER_BIT-1 and restarts at 0. It is cleared on every state entry.
- Sampled value: rx_sync at the sample point. With SERIAL_RX_MAJORITY_VOTE_EN, see Optional Feature.
- States:
  - IDLE: when rx_sync==0, go to START with timer=0.
  - START: at timer==HALF_BIT-1, sample the line.
    - Sample 1: treat as a glitch and return to IDLE; no output.
    - Sample 0: clear the timer and go to DATA with bit index 0.
  - DATA: at timer==CYCLES_PER_BIT-1, shift the sample into the shift register at position bit index (LSB first) and increment the index.
    - After index 7 is stored, go to STOP.
  - STOP: at timer==CYCLES_PER_BIT-1, sample the stop bit.
    - Sample 1: byte complete. If rx_data_available==0, or it is being cleared this cycle by rx_ready, load rx_data and set rx_data_available on the next edge. Otherwise pulse rx_overrun, discard the new byte and keep the old rx_data. Go to IDLE.
    - Sample 0: pulse rx_framing_error, discard the byte and go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_sync==1, then go to IDLE. This prevents a break condition from retriggering.
- Latency: rx_data_available rises 1 cycle after the stop-bit sample edge, i.e. about 9.5 bit times plus 3 cycles after the start falling edge on serial_rx.
- Handshake:
  - rx_data_available clears on the edge where rx_ready==1, unless a new byte loads on that same edge. In that case it stays 1 with the new data.
  - rx_ready while rx_data_available==0 is ignored.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit immediately following the stop bit is caught.
- Pulses are exactly one cycle wide and may not coincide with a load.

Optional Feature:
- Macro name: SERIAL_RX_MAJORITY_VOTE_EN.
- Defined: each sample is the 2-of-3 majority of rx_sync captured at timer values T-2, T-1 and T, where T is the sample point. This applies to start validation, data bits and the stop bit. A single-cycle glitch at the sample point is rejected.
- Undefined: single sample of rx_sync at T; no vote registers are instantiated.
- Timing and latency are identical in both builds.

Test Plan:
- (CYCLES_PER_BIT=16) Drive frame 0xA5 with rx_ready=1 -> rx_data=8'hA5 and rx_data_available high for 1 cycle; no error pulses.
- Low glitch on serial_rx of 4 cycles (< HALF_BIT), then idle -> returns to IDLE; rx_data_available stays 0. Then send 0x3C -> 0x3C received.
- Frame 0x81 with stop bit driven 0, line held low 3 bit times, then 0x42 -> one rx_framing_error pulse, no byte for 0x81, 0x42 received correctly after the line returns high.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 8'h11, one rx_overrun pulse at the end of the second frame. Raise rx_ready -> available clears.
- Pull reset low midway through the data bits of 0xFF, release, then send 0x5A -> no 0xFF output; 0x5A received.
- Loopback from the team's serial transmitter sending 0x00, 0xFF, 0x55 back-to-back (CYCLES_PER_BIT=5000) -> three bytes received in order, no errors. With SERIAL_RX_MAJORITY_VOTE_EN, additionally inject a 1-cycle inversion at every mid-bit -> bytes still correct.
